// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: FSM state encoding and
// default request field widths.
package voice_allocator_pkg;

  localparam int unsigned DEF_NOTE_BITS = 7;
  localparam int unsigned DEF_FREQ_BITS = 16;

  // Request path: capture in IDLE, select in LOOKUP, write voices in APPLY.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event request bus between the note front end (master) and the
// voice allocator (slave).
//   note_valid : request present
//   note_ready : allocator can accept a request
//   note_on    : 1 = note-on, 0 = note-off
//   note_num   : note number
//   note_freq  : frequency word for the note (ignored on note-off)
interface voice_allocator_if
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NOTE_BITS = DEF_NOTE_BITS,
  parameter int unsigned FREQ_BITS = DEF_FREQ_BITS
);

  logic                 note_valid;
  logic                 note_ready;
  logic                 note_on;
  logic [NOTE_BITS-1:0] note_num;
  logic [FREQ_BITS-1:0] note_freq;

  modport master (
    output note_valid, note_on, note_num, note_freq,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_on, note_num, note_freq,
    output note_ready
  );

endinterface

// File: rtl/voice_allocator_voice_select.sv
// Combinational voice selector for a note request.
//   gates/notes/ages : current per-voice state
//   req_note         : note number of the request
//   match_hit/idx    : lowest-index gated voice already holding req_note
//   free_hit/idx     : lowest-index voice with gate low
//   oldest_idx       : voice with the largest age, ties to the lowest index
module voice_select #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_BITS  = 7,
  parameter int unsigned AGE_BITS   = 8,
  parameter int unsigned IDX_BITS   = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]                gates,
  input  logic [NUM_VOICES-1:0][NOTE_BITS-1:0] notes,
  input  logic [NUM_VOICES-1:0][AGE_BITS-1:0]  ages,
  input  logic [NOTE_BITS-1:0]                 req_note,
  output logic                                 match_hit,
  output logic [IDX_BITS-1:0]                  match_idx,
  output logic                                 free_hit,
  output logic [IDX_BITS-1:0]                  free_idx,
  output logic [IDX_BITS-1:0]                  oldest_idx
);

  logic [AGE_BITS-1:0] best_age;

  // Ascending scan: first hit wins for match/free; strict '>' keeps the
  // lowest index on age ties.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    best_age   = ages[0];
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (!match_hit && gates[i] && (notes[i] == req_note)) begin
        match_hit = 1'b1;
        match_idx = IDX_BITS'(i);
      end
      if (!free_hit && !gates[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_BITS'(i);
      end
      if (ages[i] > best_age) begin
        best_age   = ages[i];
        oldest_idx = IDX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps a serial stream of note-on/note-off
// requests onto NUM_VOICES tone-generator voices.
//   clk, rst       : clock, asynchronous active-low reset
//   req            : note request bus (slave side)
//   all_off        : panic, releases every voice and drops any request
//   voice_freq     : voice i frequency word at [i*FREQ_BITS +: FREQ_BITS]
//   voice_gate     : gate per voice
//   voice_retrig   : one-cycle restart pulse per voice
//   voice_stolen   : one-cycle pulse when a note-on stole a gated voice
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_BITS  = DEF_NOTE_BITS,
  parameter int unsigned FREQ_BITS  = DEF_FREQ_BITS,
  parameter int unsigned AGE_BITS   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  voice_allocator_if.slave                req,
  input  logic                            all_off,
  output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES-1:0]           voice_retrig,
  output logic                            voice_stolen
);

  localparam int unsigned IDX_BITS = $clog2(NUM_VOICES);
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  state_t state_q, state_d;
  logic   ready_q;
  logic   accept;

  // Captured request
  logic                 req_on_q;
  logic [NOTE_BITS-1:0] req_note_q;
  logic [FREQ_BITS-1:0] req_freq_q;

  // Selection registered at the end of LOOKUP
  logic                match_hit_q, free_hit_q;
  logic [IDX_BITS-1:0] match_idx_q, free_idx_q, oldest_idx_q;
  logic                match_hit_c, free_hit_c;
  logic [IDX_BITS-1:0] match_idx_c, free_idx_c, oldest_idx_c;

  // Voice register file and its APPLY-time next values
  logic [NUM_VOICES-1:0][FREQ_BITS-1:0] freq_q, freq_d;
  logic [NUM_VOICES-1:0][NOTE_BITS-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0][AGE_BITS-1:0]  age_q, age_d;
  logic [NUM_VOICES-1:0]                gate_q, gate_d;
  logic [NUM_VOICES-1:0]                retrig_q, retrig_d;
  logic                                 stolen_q, stolen_d;
  logic [IDX_BITS-1:0]                  sel_idx;

  // all_off also blocks acceptance so a request never slips past the panic.
  assign accept = req.note_valid && ready_q && !all_off;

  assign req.note_ready = ready_q;
  assign voice_freq     = freq_q;
  assign voice_gate     = gate_q;
  assign voice_retrig   = retrig_q;
  assign voice_stolen   = stolen_q;

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_BITS  (NOTE_BITS),
    .AGE_BITS   (AGE_BITS),
    .IDX_BITS   (IDX_BITS)
  ) u_select (
    .gates      (gate_q),
    .notes      (note_q),
    .ages       (age_q),
    .req_note   (req_note_q),
    .match_hit  (match_hit_c),
    .match_idx  (match_idx_c),
    .free_hit   (free_hit_c),
    .free_idx   (free_idx_c),
    .oldest_idx (oldest_idx_c)
  );

  // Next-state logic; all_off returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_APPLY;
      ST_APPLY:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (all_off) state_d = ST_IDLE;
  end

  // State and registered ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE) && !all_off;
    end
  end

  // Request capture and LOOKUP-time selection registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_on_q     <= 1'b0;
      req_note_q   <= '0;
      req_freq_q   <= '0;
      match_hit_q  <= 1'b0;
      match_idx_q  <= '0;
      free_hit_q   <= 1'b0;
      free_idx_q   <= '0;
      oldest_idx_q <= '0;
    end else begin
      if (accept) begin
        req_on_q   <= req.note_on;
        req_note_q <= req.note_num;
        req_freq_q <= req.note_freq;
      end
      if (state_q == ST_LOOKUP && !all_off) begin
        match_hit_q  <= match_hit_c;
        match_idx_q  <= match_idx_c;
        free_hit_q   <= free_hit_c;
        free_idx_q   <= free_idx_c;
        oldest_idx_q <= oldest_idx_c;
      end
    end
  end

  // Voice updates applied at the closing edge of APPLY.
  always_comb begin
    freq_d   = freq_q;
    note_d   = note_q;
    age_d    = age_q;
    gate_d   = gate_q;
    retrig_d = '0;
    stolen_d = 1'b0;
    sel_idx  = '0;
    if (req_on_q) begin
      if (match_hit_q) begin
        sel_idx = match_idx_q;
      end else if (free_hit_q) begin
        sel_idx = free_idx_q;
      end else begin
        sel_idx  = oldest_idx_q;
        stolen_d = 1'b1;
      end
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (IDX_BITS'(i) == sel_idx) begin
          freq_d[i]   = req_freq_q;
          note_d[i]   = req_note_q;
          gate_d[i]   = 1'b1;
          age_d[i]    = '0;
          retrig_d[i] = 1'b1;
        end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
          age_d[i] = age_q[i] + AGE_BITS'(1);
        end
      end
    end else begin
      // Note-off releases every match; freq/note stay for the release tail.
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (gate_q[i] && (note_q[i] == req_note_q)) gate_d[i] = 1'b0;
      end
    end
  end

  // Voice register file; pulses default low so they last one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_q   <= '0;
      note_q   <= '0;
      age_q    <= '0;
      gate_q   <= '0;
      retrig_q <= '0;
      stolen_q <= 1'b0;
    end else begin
      retrig_q <= '0;
      stolen_q <= 1'b0;
      if (all_off) begin
        gate_q <= '0;
        age_q  <= '0;
      end else if (state_q == ST_APPLY) begin
        freq_q   <= freq_d;
        note_q   <= note_d;
        age_q    <= age_d;
        gate_q   <= gate_d;
        retrig_q <= retrig_d;
        stolen_q <= stolen_d;
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 voices, 7-bit notes, 16-bit freq).
module tb_voice_allocator;

  logic        clk;
  logic        rst;
  logic        all_off;
  logic [63:0] voice_freq;
  logic [3:0]  voice_gate;
  logic [3:0]  voice_retrig;
  logic        voice_stolen;

  int errors = 0;
  int checks = 0;

  voice_allocator_if #(.NOTE_BITS(7), .FREQ_BITS(16)) bus ();

  voice_allocator #(
    .NUM_VOICES (4),
    .NOTE_BITS  (7),
    .FREQ_BITS  (16),
    .AGE_BITS   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.slave),
    .all_off      (all_off),
    .voice_freq   (voice_freq),
    .voice_gate   (voice_gate),
    .voice_retrig (voice_retrig),
    .voice_stolen (voice_stolen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and wait (bounded) for the accept edge.
  task automatic present(input logic on, input logic [6:0] num, input logic [15:0] freq);
    int n;
    @(negedge clk);
    bus.note_valid = 1'b1;
    bus.note_on    = on;
    bus.note_num   = num;
    bus.note_freq  = freq;
    n = 0;
    while (!bus.note_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(bus.note_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.note_valid = 1'b0;
  endtask

  // Full transaction with checks on handshake, outputs and pulse width.
  task automatic do_note(input string tag, input logic on, input logic [6:0] num,
                         input logic [15:0] freq, input logic [3:0] exp_gate,
                         input logic [3:0] exp_retrig, input logic exp_stolen);
    present(on, num, freq);
    chk({tag, ".ready_e0"}, 64'(bus.note_ready), 64'(0));
    @(posedge clk); #1;
    chk({tag, ".ready_e1"}, 64'(bus.note_ready), 64'(0));
    @(posedge clk); #1;
    chk({tag, ".ready_e2"}, 64'(bus.note_ready), 64'(1));
    chk({tag, ".gate"}, 64'(voice_gate), 64'(exp_gate));
    chk({tag, ".retrig"}, 64'(voice_retrig), 64'(exp_retrig));
    chk({tag, ".stolen"}, 64'(voice_stolen), 64'(exp_stolen));
    @(posedge clk); #1;
    chk({tag, ".retrig_end"}, 64'(voice_retrig), 64'(0));
    chk({tag, ".stolen_end"}, 64'(voice_stolen), 64'(0));
  endtask

  initial begin
    rst            = 1'b0;
    all_off        = 1'b0;
    bus.note_valid = 1'b0;
    bus.note_on    = 1'b0;
    bus.note_num   = '0;
    bus.note_freq  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst.ready", 64'(bus.note_ready), 64'(1));
    chk("rst.gate", 64'(voice_gate), 64'(0));
    chk("rst.freq", voice_freq, 64'h0);
    chk("rst.retrig", 64'(voice_retrig), 64'(0));
    chk("rst.stolen", 64'(voice_stolen), 64'(0));

    // First note-on lands on voice 0
    do_note("on60", 1'b1, 7'd60, 16'h1234, 4'b0001, 4'b0001, 1'b0);
    chk("on60.freq", voice_freq, 64'h0000_0000_0000_1234);

    // Fill the bank; 60 is already on voice 0 so it retriggers there
    do_note("fill60", 1'b1, 7'd60, 16'h1000, 4'b0001, 4'b0001, 1'b0);
    do_note("fill62", 1'b1, 7'd62, 16'h1001, 4'b0011, 4'b0010, 1'b0);
    do_note("fill64", 1'b1, 7'd64, 16'h1002, 4'b0111, 4'b0100, 1'b0);
    do_note("fill65", 1'b1, 7'd65, 16'h1003, 4'b1111, 4'b1000, 1'b0);
    chk("fill.freq", voice_freq, 64'h1003_1002_1001_1000);

    // Full bank: steal the oldest (voice 0, age 3)
    do_note("steal67", 1'b1, 7'd67, 16'h2000, 4'b1111, 4'b0001, 1'b1);
    chk("steal67.freq", voice_freq, 64'h1003_1002_1001_2000);

    // Note-off 62 frees voice 1, freq retained
    do_note("off62", 1'b0, 7'd62, 16'hFFFF, 4'b1101, 4'b0000, 1'b0);
    chk("off62.freq", voice_freq, 64'h1003_1002_1001_2000);

    // Lowest free voice is 1
    do_note("on69", 1'b1, 7'd69, 16'h2100, 4'b1111, 4'b0010, 1'b0);
    chk("on69.freq", voice_freq, 64'h1003_1002_2100_2000);

    // Same-note retrigger on voice 2; ages now v0=2 v1=1 v2=0 v3=3
    do_note("re64", 1'b1, 7'd64, 16'h3000, 4'b1111, 4'b0100, 1'b0);
    chk("re64.freq", voice_freq, 64'h1003_3000_2100_2000);

    // Oldest is voice 3, then voice 0 (age 3 after the previous steal)
    do_note("steal71", 1'b1, 7'd71, 16'h4000, 4'b1111, 4'b1000, 1'b1);
    chk("steal71.freq", voice_freq, 64'h4000_3000_2100_2000);
    do_note("steal72", 1'b1, 7'd72, 16'h4100, 4'b1111, 4'b0001, 1'b1);
    chk("steal72.freq", voice_freq, 64'h4000_3000_2100_4100);

    // Note-off with no matching voice changes nothing
    do_note("off99", 1'b0, 7'd99, 16'h0000, 4'b1111, 4'b0000, 1'b0);

    // all_off during LOOKUP of note-on 70
    present(1'b1, 7'd70, 16'h5555);
    @(negedge clk);
    all_off = 1'b1;
    @(posedge clk); #1;
    chk("alloff.gate", 64'(voice_gate), 64'(0));
    chk("alloff.retrig", 64'(voice_retrig), 64'(0));
    chk("alloff.ready", 64'(bus.note_ready), 64'(0));
    @(posedge clk); #1;
    chk("alloff.ready_hold", 64'(bus.note_ready), 64'(0));
    chk("alloff.retrig_hold", 64'(voice_retrig), 64'(0));
    chk("alloff.freq", voice_freq, 64'h4000_3000_2100_4100);
    @(negedge clk);
    all_off = 1'b0;
    #1;
    chk("alloff.ready_fall", 64'(bus.note_ready), 64'(0));
    @(posedge clk); #1;
    chk("alloff.ready_back", 64'(bus.note_ready), 64'(1));
    chk("alloff.dropped", 64'(voice_gate), 64'(0));
    chk("alloff.no_retrig", 64'(voice_retrig), 64'(0));

    // After panic every voice is free: next note goes to voice 0
    do_note("post_off", 1'b1, 7'd70, 16'h5000, 4'b0001, 4'b0001, 1'b0);
    chk("post_off.freq", voice_freq, 64'h4000_3000_2100_5000);

    // Asynchronous reset in the middle of APPLY
    present(1'b1, 7'd80, 16'h6000);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst.gate", 64'(voice_gate), 64'(0));
    chk("arst.freq", voice_freq, 64'h0);
    chk("arst.retrig", 64'(voice_retrig), 64'(0));
    chk("arst.stolen", 64'(voice_stolen), 64'(0));
    chk("arst.ready", 64'(bus.note_ready), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("arst.idle", 64'(voice_gate), 64'(0));
    do_note("arst_on81", 1'b1, 7'd81, 16'h7000, 4'b0001, 4'b0001, 1'b0);
    chk("arst_on81.freq", voice_freq, 64'h0000_0000_0000_7000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic note scheduler that shares a bank of NUM_VOICES tone-generator voices between a serial stream of note-on/note-off requests.
- Per voice, it drives a frequency word, a gate and a retrigger pulse. These feed each voice's tone-generator frequency input and the downstream envelope stage.
- It sits between the note-event front end (MIDI/UART decoder) and the voice array.
- Allocation priority on note-on: existing same-note voice first, then lowest-index free voice, then steal the oldest voice.

Parameters:
NUM_VOICES, 4, number of tone-generator voices managed (2..16)
NOTE_BITS, 7, note number width
FREQ_BITS, 16, width of per-voice frequency word (matches tone_freq)
AGE_BITS, 8, per-voice saturating age counter width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (low = reset)
note_valid  in  1  request present
note_ready  out  1  allocator can accept request
note_on  in  1  1 = note-on, 0 = note-off
note_num  in  NOTE_BITS  note number
note_freq  in  FREQ_BITS  frequency word for note (ignored on note-off)
all_off  in  1  panic: release every voice
voice_freq  out  NUM_VOICES*FREQ_BITS  voice i at [i*FREQ_BITS +: FREQ_BITS]
voice_gate  out  NUM_VOICES  gate per voice
voice_retrig  out  NUM_VOICES  1-cycle restart pulse per voice
voice_stolen  out  1  1-cycle pulse when a note-on stole a gated voice

Behaviour:
- Reset (rst low, async): FSM=IDLE, note_ready=1. voice_freq, voice_gate, voice_retrig, voice_stolen, stored notes and ages all 0.
- Handshake: request accepted on a rising edge with note_valid&&note_ready. Request fields are captured at that edge. note_ready=1 only in IDLE with all_off=0.
- FSM:
  - IDLE: on accept -> LOOKUP.
  - LOOKUP (1 cycle): compute match/free/oldest from captured request; register selection -> APPLY.
  - APPLY (1 cycle): update voice registers at the closing edge -> IDLE.
- Latency: voice outputs change at the 2nd edge after the accept edge. note_ready is low for exactly 2 cycles. Max throughput is 1 request per 3 cycles.
- Note-on selection, in priority order:
  - (a) lowest-index voice with gate=1 and stored note==note_num (retrigger);
  - (b) else lowest-index voice with gate=0;
  - (c) else voice with largest age, ties broken to the lowest index; voice_stolen pulses.
- Note-on writes to the selected voice i: freq=note_freq, note=note_num, gate=1, age=0. voice_retrig[i]=1 for the cycle following APPLY.
- On every note-on, every other gated voice has its age incremented, saturating at 2^AGE_BITS-1. Free voices keep age unchanged.
- Note-off: every gated voice whose stored note==note_num gets gate=0. freq and note are retained so release continues. No match -> no change. No retrig, no stolen pulse.
- voice_retrig and voice_stolen are registered. They are high only in the single cycle after the APPLY edge and 0 otherwise.
- all_off is sampled each edge and has priority over everything. While high:
  - all gates, ages and pulses are forced to 0; freq is retained;
  - FSM is forced to IDLE and any in-flight request is discarded;
  - note_ready=0.
  note_ready returns 1 on the cycle after all_off falls.
- Reset mid-operation: immediate clear of everything; the in-flight request is lost.
- Simultaneous same-note duplicates cannot exist, because (a) precedes (b). Note-off clears all matches regardless.

Decomposition:
- Shared synth package: FSM state encoding (IDLE/LOOKUP/APPLY), default NOTE_BITS/FREQ_BITS.
- Sub-module voice_select: combinational priority selector. Takes gates, notes, ages and the request note. Outputs match_hit/match_idx, free_hit/free_idx, oldest_idx. Registered in LOOKUP by the parent.
- Parent holds the FSM, per-voice register file and pulse generation.

Test Plan:
- Reset, then note-on 60, freq 0x1234 -> 2 edges later voice_gate=0001, voice 0 freq=0x1234, voice_retrig=0001 for 1 cycle, voice_stolen=0; note_ready low exactly 2 cycles.
- Note-ons 60, 62, 64, 65 (freqs 0x1000..0x1003) -> gates=1111, voices 0..3. Note-on 67, freq 0x2000 -> voice 0 freq=0x2000, gate stays 1, voice_retrig=0001, voice_stolen pulse.
- From the full state, note-off 62 -> gate=1101, voice 1 freq unchanged. Then note-on 69 -> voice 1 (lowest free), voice_stolen=0.
- Note-on 64 while voice 2 holds 64 -> voice 2 retrigger only; other voices' freq/gate unchanged; voice 2 age=0, others age+1; no steal.
- Assert all_off during LOOKUP of note-on 70 -> next edge gate=0000, no retrig pulse, request dropped; note_ready=1 one cycle after all_off deasserts.
- Pull rst low asynchronously mid-APPLY -> all outputs 0 immediately without a clock edge; after release, note_ready=1 and the first note-on lands on voice 0.
